// File: rtl/p2s_tx32.sv
// Parallel-to-serial transmitter: shifts a captured word out on s_clk/s_dat, then strobes s_latch.
// Define P2S_LSB_FIRST_EN to send D[0] first instead of D[DATA_W-1].
module p2s_tx32 #(
  parameter int DATA_W = 32,
  parameter int DIV    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] D,
  output logic              busy,
  output logic              done,
  output logic              s_clk,
  output logic              s_dat,
  output logic              s_latch
);

  localparam int BC_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int HC_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [BC_W-1:0] BC_LAST = BC_W'(DATA_W - 1);
  localparam logic [HC_W-1:0] HC_LAST = HC_W'(DIV - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOW,
    ST_HIGH,
    ST_LATCH,
    ST_FIN
  } state_t;

  state_t            r_state;
  logic [DATA_W-1:0] r_shift;
  logic [BC_W-1:0]   r_bcnt;
  logic [HC_W-1:0]   r_hcnt;
  logic              r_busy;
  logic              r_done;
  logic              r_sclk;
  logic              r_dat;
  logic              r_latch;

  logic              w_hc_wrap;
  logic              w_first_bit;
  logic              w_next_bit;
  logic [DATA_W-1:0] w_shifted;

  assign w_hc_wrap = (r_hcnt == HC_LAST);

`ifdef P2S_LSB_FIRST_EN
  assign w_first_bit = D[0];
  assign w_next_bit  = r_shift[1];
  assign w_shifted   = r_shift >> 1;
`else
  assign w_first_bit = D[DATA_W-1];
  assign w_next_bit  = r_shift[DATA_W-2];
  assign w_shifted   = r_shift << 1;
`endif

  // s_dat only moves on the HIGH->LOW edge, so it is stable across each s_clk rise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_shift <= '0;
      r_bcnt  <= '0;
      r_hcnt  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_sclk  <= 1'b0;
      r_dat   <= 1'b0;
      r_latch <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_shift <= D;
            r_dat   <= w_first_bit;
            r_bcnt  <= '0;
            r_hcnt  <= '0;
            r_busy  <= 1'b1;
            r_sclk  <= 1'b0;
            r_state <= ST_LOW;
          end
        end
        ST_LOW: begin
          if (w_hc_wrap) begin
            r_hcnt  <= '0;
            r_sclk  <= 1'b1;
            r_state <= ST_HIGH;
          end else begin
            r_hcnt <= r_hcnt + HC_W'(1);
          end
        end
        ST_HIGH: begin
          if (w_hc_wrap) begin
            r_hcnt <= '0;
            r_sclk <= 1'b0;
            if (r_bcnt == BC_LAST) begin
              r_latch <= 1'b1;
              r_state <= ST_LATCH;
            end else begin
              r_shift <= w_shifted;
              r_dat   <= w_next_bit;
              r_bcnt  <= r_bcnt + BC_W'(1);
              r_state <= ST_LOW;
            end
          end else begin
            r_hcnt <= r_hcnt + HC_W'(1);
          end
        end
        ST_LATCH: begin
          if (w_hc_wrap) begin
            r_hcnt  <= '0;
            r_latch <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= ST_FIN;
          end else begin
            r_hcnt <= r_hcnt + HC_W'(1);
          end
        end
        ST_FIN: begin
          r_done  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy    = r_busy;
  assign done    = r_done;
  assign s_clk   = r_sclk;
  assign s_dat   = r_dat;
  assign s_latch = r_latch;

endmodule

// File: tb/tb_p2s_tx32.sv
// Directed bench for p2s_tx32: default 32-bit/DIV=2 instance plus an 8-bit/DIV=1 instance.
// Build with P2S_LSB_FIRST_EN defined to check the LSB-first stream.
module tb_p2s_tx32;

`ifdef P2S_LSB_FIRST_EN
  localparam logic [31:0] EXP_PAT  = 32'h69F0_C3A5;
  localparam logic [31:0] EXP_REJ  = 32'h1E6A_2C48;
  localparam logic [31:0] EXP_ALT  = 32'hF0F0_F0F0;
  localparam logic [31:0] EXP_FF   = 32'hFF00_0000;
`else
  localparam logic [31:0] EXP_PAT  = 32'hA5C3_0F96;
  localparam logic [31:0] EXP_REJ  = 32'h1234_5678;
  localparam logic [31:0] EXP_ALT  = 32'h0F0F_0F0F;
  localparam logic [31:0] EXP_FF   = 32'h0000_00FF;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        start_a, start_b;
  logic [31:0] d_a;
  logic [7:0]  d_b;
  logic        busy_a, done_a, sclk_a, dat_a, latch_a;
  logic        busy_b, done_b, sclk_b, dat_b, latch_b;

  always #5 clk = ~clk;

  p2s_tx32 #(.DATA_W(32), .DIV(2)) u_dut_a (
    .clk(clk), .rst(rst), .start(start_a), .D(d_a),
    .busy(busy_a), .done(done_a), .s_clk(sclk_a), .s_dat(dat_a), .s_latch(latch_a)
  );

  p2s_tx32 #(.DATA_W(8), .DIV(1)) u_dut_b (
    .clk(clk), .rst(rst), .start(start_b), .D(d_b),
    .busy(busy_b), .done(done_b), .s_clk(sclk_b), .s_dat(dat_b), .s_latch(latch_b)
  );

  // View of whichever instance the current transfer targets.
  bit   sel_b = 1'b0;
  logic c_busy, c_done, c_sclk, c_dat, c_latch;
  always_comb begin
    c_busy  = sel_b ? busy_b  : busy_a;
    c_done  = sel_b ? done_b  : done_a;
    c_sclk  = sel_b ? sclk_b  : sclk_a;
    c_dat   = sel_b ? dat_b   : dat_a;
    c_latch = sel_b ? latch_b : latch_a;
  end

  int n_checks = 0;
  int n_err    = 0;

  logic [31:0] cap;
  int rises, busy_first, busy_last, latch_first, latch_last, done_cyc, done_cnt, viol;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input bit use_b, input logic s, input logic [31:0] d);
    if (use_b) begin
      start_b = s;
      d_b     = d[7:0];
    end else begin
      start_a = s;
      d_a     = d;
    end
  endtask

  // Present d for one cycle (cycle 0), then observe cycles 1..ncyc.
  task automatic xfer(input bit use_b, input logic [31:0] d, input bit scramble,
                      input int rej1, input int rej2, input int ncyc);
    logic prev_sclk, prev_dat, pulse;
    sel_b = use_b;
    cap = '0; rises = 0; busy_first = 0; busy_last = 0; latch_first = 0;
    latch_last = 0; done_cyc = 0; done_cnt = 0; viol = 0;
    prev_sclk = 1'b0; prev_dat = 1'b0;
    @(negedge clk);
    drive(use_b, 1'b1, d);
    @(posedge clk);
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      if (c_sclk && !prev_sclk) begin
        rises++;
        cap = {cap[30:0], c_dat};
      end
      if (prev_sclk && c_sclk && (c_dat != prev_dat)) viol++;
      if (c_latch && c_sclk) viol++;
      if (c_busy) begin
        if (busy_first == 0) busy_first = c;
        busy_last = c;
      end
      if (c_latch) begin
        if (latch_first == 0) latch_first = c;
        latch_last = c;
      end
      if (c_done) begin
        done_cnt++;
        done_cyc = c;
      end
      prev_sclk = c_sclk;
      prev_dat  = c_dat;
      pulse = (c == rej1) || (c == rej2);
      if (pulse)         drive(use_b, 1'b1, 32'hFFFF_FFFF);
      else if (scramble) drive(use_b, 1'b0, $urandom);
      else               drive(use_b, 1'b0, d);
    end
  endtask

  task automatic verify(input string tag, input logic [31:0] exp_cap, input int exp_rises,
                        input int exp_busy_last, input int exp_latch_first,
                        input int exp_latch_last, input int exp_done);
    $display("xfer %s: cap=%08h rises=%0d busy=%0d..%0d latch=%0d..%0d done@%0d x%0d",
             tag, cap, rises, busy_first, busy_last, latch_first, latch_last, done_cyc, done_cnt);
    check({tag, ".cap"},         cap,         exp_cap);
    check({tag, ".rises"},       rises,       exp_rises);
    check({tag, ".busy_first"},  busy_first,  1);
    check({tag, ".busy_last"},   busy_last,   exp_busy_last);
    check({tag, ".latch_first"}, latch_first, exp_latch_first);
    check({tag, ".latch_last"},  latch_last,  exp_latch_last);
    check({tag, ".done_cyc"},    done_cyc,    exp_done);
    check({tag, ".done_cnt"},    done_cnt,    1);
    check({tag, ".stable"},      viol,        0);
  endtask

  initial begin
    rst = 1'b1;
    start_a = 1'b0; start_b = 1'b0; d_a = '0; d_b = '0;
    repeat (3) @(negedge clk);
    check("rst.outs_a", {27'd0, busy_a, done_a, sclk_a, dat_a, latch_a}, 32'd0);
    check("rst.outs_b", {27'd0, busy_b, done_b, sclk_b, dat_b, latch_b}, 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    xfer(1'b0, 32'h8000_0001, 1'b0, -1, -1, 131);
    verify("basic", 32'h8000_0001, 32, 130, 129, 130, 131);

    xfer(1'b0, 32'hA5C3_0F96, 1'b0, -1, -1, 131);
    verify("pattern", EXP_PAT, 32, 130, 129, 130, 131);

    xfer(1'b0, 32'h1234_5678, 1'b0, 10, 131, 131);
    verify("reject", EXP_REJ, 32, 130, 129, 130, 131);

    // Started at cycle 132 of the previous transfer, with D scrambled every cycle.
    xfer(1'b0, 32'h0F0F_0F0F, 1'b1, -1, -1, 131);
    verify("b2b_isolate", EXP_ALT, 32, 130, 129, 130, 131);

    // Reset abort at cycle 40.
    sel_b = 1'b0;
    @(negedge clk);
    drive(1'b0, 1'b1, 32'hDEAD_BEEF);
    @(posedge clk);
    for (int c = 1; c < 40; c++) begin
      @(negedge clk);
      drive(1'b0, 1'b0, 32'hDEAD_BEEF);
    end
    @(negedge clk);
    check("abort.busy_before", {31'd0, busy_a}, 32'd1);
    rst = 1'b1;
    #1;
    check("abort.outs", {27'd0, busy_a, done_a, sclk_a, dat_a, latch_a}, 32'd0);
    done_cnt = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (done_a) done_cnt++;
    end
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (done_a) done_cnt++;
    end
    check("abort.no_done", done_cnt, 0);
    $display("xfer abort: rst at cycle 40, outputs cleared");

    xfer(1'b0, 32'h0000_00FF, 1'b0, -1, -1, 131);
    verify("after_abort", EXP_FF, 32, 130, 129, 130, 131);

    xfer(1'b1, 32'h0000_003C, 1'b0, -1, -1, 18);
    verify("w8_div1", 32'h0000_003C, 8, 17, 17, 17, 18);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
